// File: rtl/gs_lsu_pkg.sv
// Shared types and helpers for the gs_lsu load/store unit.
// The optional performance counters are enabled with the GS_LSU_PERF_EN macro.
package gs_lsu_pkg;

    // Access size as encoded on req_size. 2'b11 is not a legal size.
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_e;

    // LSU sequencing states.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } lsu_state_e;

    // Request fields that must survive past the accept cycle.
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } lsu_req_t;

    // True when an access cannot be issued to the SRAM: the address is not
    // naturally aligned for its size, or the size code itself is illegal.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/gs_lsu_if.sv
// Core <-> LSU request/response handshake bundle.
// master = core side, slave = LSU side.
interface gs_lsu_if #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [ADDR_SIZE-1:0] req_addr;
    logic [WORD_SIZE-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/gs_lsu_align.sv
// Combinational byte-lane logic for the LSU.
// Store side: replicate byte/half data across lanes and build the active-low
// write-enable mask. Load side: pick the addressed lane(s) and extend.
module gs_lsu_align
    import gs_lsu_pkg::*;
#(
    parameter int WORD_SIZE = 32,
    parameter int BYTES     = WORD_SIZE / 8
) (
    input  logic [1:0]           st_size,
    input  logic [1:0]           st_off,
    input  logic [WORD_SIZE-1:0] st_wdata,
    output logic [BYTES-1:0]     st_web,
    output logic [WORD_SIZE-1:0] st_di,
    input  logic [1:0]           ld_size,
    input  logic [1:0]           ld_off,
    input  logic                 ld_unsigned,
    input  logic [WORD_SIZE-1:0] ld_raw,
    output logic [WORD_SIZE-1:0] ld_data
);

    generate
        for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic [7:0] lane_di;
            logic       lane_web;

            // Per-lane store data and write strobe for the current size/offset.
            always_comb begin
                lane_di  = st_wdata[8*gi +: 8];
                lane_web = 1'b1;
                case (st_size)
                    SIZE_B: begin
                        lane_di  = st_wdata[7:0];
                        lane_web = (LANE != st_off);
                    end
                    SIZE_H: begin
                        lane_di  = st_wdata[8*(gi%2) +: 8];
                        lane_web = (LANE[1] != st_off[1]);
                    end
                    SIZE_W: begin
                        lane_di  = st_wdata[8*gi +: 8];
                        lane_web = 1'b0;
                    end
                    default: begin
                        lane_di  = st_wdata[8*gi +: 8];
                        lane_web = 1'b1;
                    end
                endcase
            end

            assign st_di[8*gi +: 8] = lane_di;
            assign st_web[gi]       = lane_web;
        end
    endgenerate

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Select the addressed byte/half from the read word and sign/zero-extend.
    always_comb begin
        ld_byte = ld_raw[{ld_off, 3'b000} +: 8];
        ld_half = ld_raw[{ld_off[1], 4'b0000} +: 16];
        case (ld_size)
            SIZE_B:  ld_data = {{(WORD_SIZE-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
            SIZE_H:  ld_data = {{(WORD_SIZE-16){~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/gs_lsu.sv
// gs_lsu: core-side load/store initiator for the SRAM data-memory port.
// One request in flight; registered SRAM pins; one response per request.
// Define GS_LSU_PERF_EN to add load/store/error response counters.
module gs_lsu
    import gs_lsu_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int BYTES     = WORD_SIZE / 8,
    parameter int MEM_AW    = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    gs_lsu_if.slave              bus,
    output logic                 mem_oe,
    output logic [BYTES-1:0]     mem_web,
    output logic [MEM_AW-1:0]    mem_addr,
    output logic [WORD_SIZE-1:0] mem_di,
    input  logic [WORD_SIZE-1:0] mem_do
`ifdef GS_LSU_PERF_EN
    ,
    output logic [31:0]          perf_ld_cnt,
    output logic [31:0]          perf_st_cnt,
    output logic [31:0]          perf_err_cnt
`endif
);

    lsu_state_e           state_reg;
    lsu_req_t             req_reg;
    logic                 req_ready_reg;
    logic                 rsp_valid_reg;
    logic                 rsp_err_reg;
    logic [WORD_SIZE-1:0] rsp_rdata_reg;
    logic                 mem_oe_reg;
    logic [BYTES-1:0]     mem_web_reg;
    logic [MEM_AW-1:0]    mem_addr_reg;
    logic [WORD_SIZE-1:0] mem_di_reg;

    logic [BYTES-1:0]     st_web;
    logic [WORD_SIZE-1:0] st_di;
    logic [WORD_SIZE-1:0] ld_data;

    // Address bits above the SRAM word range are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[ADDR_SIZE-1:MEM_AW+2];

    // Store steering works on the live request so pins can be loaded at accept;
    // load extension works on the latched request and the SRAM read data.
    gs_lsu_align #(
        .WORD_SIZE (WORD_SIZE),
        .BYTES     (BYTES)
    ) u_align (
        .st_size     (bus.req_size),
        .st_off      (bus.req_addr[1:0]),
        .st_wdata    (bus.req_wdata),
        .st_web      (st_web),
        .st_di       (st_di),
        .ld_size     (req_reg.size),
        .ld_off      (req_reg.off),
        .ld_unsigned (req_reg.uns),
        .ld_raw      (mem_do),
        .ld_data     (ld_data)
    );

    // Main sequencer: request capture, SRAM pin registers and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            req_reg       <= '0;
            req_ready_reg <= 1'b1;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
            mem_oe_reg    <= 1'b0;
            mem_web_reg   <= '1;
            mem_addr_reg  <= '0;
            mem_di_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        req_reg.we    <= bus.req_we;
                        req_reg.size  <= bus.req_size;
                        req_reg.uns   <= bus.req_unsigned;
                        req_reg.off   <= bus.req_addr[1:0];
                        req_ready_reg <= 1'b0;
                        if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                            // Rejected accesses never touch the SRAM pins.
                            state_reg     <= RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_rdata_reg <= '0;
                        end else begin
                            state_reg    <= ACCESS;
                            mem_addr_reg <= bus.req_addr[MEM_AW+1:2];
                            if (bus.req_we) begin
                                mem_web_reg <= st_web;
                                mem_di_reg  <= st_di;
                            end else begin
                                mem_oe_reg  <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    // The SRAM samples the pins on this edge; release them.
                    mem_oe_reg  <= 1'b0;
                    mem_web_reg <= '1;
                    if (req_reg.we) begin
                        state_reg     <= RESP;
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        rsp_rdata_reg <= '0;
                    end else begin
                        state_reg <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    state_reg     <= RESP;
                    rsp_valid_reg <= 1'b1;
                    rsp_err_reg   <= 1'b0;
                    rsp_rdata_reg <= ld_data;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    rsp_valid_reg <= 1'b0;
                    mem_oe_reg    <= 1'b0;
                    mem_web_reg   <= '1;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_err   = rsp_err_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign mem_oe        = mem_oe_reg;
    assign mem_web       = mem_web_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_di        = mem_di_reg;

`ifdef GS_LSU_PERF_EN
    logic [31:0] perf_ld_reg;
    logic [31:0] perf_st_reg;
    logic [31:0] perf_err_reg;

    // Count completed responses by kind; counters wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_ld_reg  <= '0;
            perf_st_reg  <= '0;
            perf_err_reg <= '0;
        end else if (rsp_valid_reg && bus.rsp_ready) begin
            if (rsp_err_reg) begin
                perf_err_reg <= perf_err_reg + 32'd1;
            end else if (req_reg.we) begin
                perf_st_reg  <= perf_st_reg + 32'd1;
            end else begin
                perf_ld_reg  <= perf_ld_reg + 32'd1;
            end
        end
    end

    assign perf_ld_cnt  = perf_ld_reg;
    assign perf_st_cnt  = perf_st_reg;
    assign perf_err_cnt = perf_err_reg;
`endif

endmodule

// File: tb/tb_gs_lsu.sv
// Self-checking bench for gs_lsu: directed spec scenarios then randomized
// traffic, checked against a byte-addressed reference memory.
// Define GS_LSU_PERF_EN to also exercise the performance counters.
`timescale 1ns/1ps

module tb_gs_lsu;

    logic        clk;
    logic        rst;
    logic        mem_oe;
    logic [3:0]  mem_web;
    logic [13:0] mem_addr;
    logic [31:0] mem_di;
    logic [31:0] mem_do;
`ifdef GS_LSU_PERF_EN
    logic [31:0] perf_ld_cnt;
    logic [31:0] perf_st_cnt;
    logic [31:0] perf_err_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    int exp_ld = 0;
    int exp_st = 0;
    int exp_er = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    gs_lsu_if #(.ADDR_SIZE(32), .WORD_SIZE(32)) bus ();

    gs_lsu dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .mem_oe   (mem_oe),
        .mem_web  (mem_web),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .mem_do   (mem_do)
`ifdef GS_LSU_PERF_EN
        ,
        .perf_ld_cnt  (perf_ld_cnt),
        .perf_st_cnt  (perf_st_cnt),
        .perf_err_cnt (perf_err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: registered read data, per-byte active-low writes, plus a
    // bench-only preload port.
    logic [31:0] sram [0:16383];
    logic        pre_we;
    logic [13:0] pre_addr;
    logic [31:0] pre_data;

    always @(posedge clk) begin
        if (mem_oe) mem_do <= sram[mem_addr];
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else begin
            for (int b = 0; b < 4; b++)
                if (!mem_web[b]) sram[mem_addr][8*b +: 8] <= mem_di[8*b +: 8];
        end
    end

    // Reference memory, byte addressed by the low 16 address bits.
    logic [7:0] ref_mem [0:65535];

    function automatic int size_bytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns);
        logic [63:0] v;
        logic [15:0] idx;
        int nb;
        nb = size_bytes(size);
        v = 64'd0;
        for (int i = 0; i < nb; i++) begin
            idx = addr[15:0] + 16'(i);
            v = v + (64'(ref_mem[idx]) << (8 * i));
        end
        if (!uns && nb < 4 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1)
            v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    // Preload one SRAM word and the matching reference bytes (called at a negedge).
    task automatic preload(input logic [13:0] waddr, input logic [31:0] data);
        pre_we = 1'b1;
        pre_addr = waddr;
        pre_data = data;
        for (int i = 0; i < 4; i++) ref_mem[{waddr, 2'(i)}] = data[8*i +: 8];
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // One full request/response transaction; called just after a negedge.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic        err;
        int          nb;
        int          lat;
        int          exp_lat;
        logic [3:0]  exp_web;
        logic [31:0] exp_di;
        logic [31:0] exp_rd;
        logic [15:0] idx;

        err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        nb = size_bytes(size);
        exp_web = 4'hF;
        for (int i = 0; i < nb; i++) exp_web[addr[1:0] + i] = 1'b0;
        exp_di = (size == 2'd0) ? 32'(wdata[7:0]) * 32'h0101_0101 :
                 (size == 2'd1) ? 32'(wdata[15:0]) * 32'h0001_0001 : wdata;
        exp_rd = (err || we) ? 32'd0 : ref_load(addr, size, uns);
        exp_lat = err ? 1 : (we ? 2 : 3);

        chk("req_ready_idle", bus.req_ready, 1'b1);
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_size = size;
        bus.req_unsigned = uns;
        bus.req_addr = addr;
        bus.req_wdata = wdata;
        bus.rsp_ready = (hold == 0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        lat = 0;
        while (lat <= 8) begin
            @(negedge clk);
            lat++;
            if (!err && lat == 1) begin
                chk("pin_oe_access", mem_oe, !we);
                chk("pin_web_access", mem_web, we ? exp_web : 4'hF);
                chk("pin_addr_access", mem_addr, addr[15:2]);
                if (we) chk("pin_di_access", mem_di, exp_di);
            end else begin
                chk("pin_oe_idle", mem_oe, 1'b0);
                chk("pin_web_idle", mem_web, 4'hF);
            end
            if (bus.rsp_valid) break;
        end
        chk("rsp_latency", lat, exp_lat);
        chk("rsp_err", bus.rsp_err, err);
        chk("rsp_rdata", bus.rsp_rdata, exp_rd);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
            chk("hold_rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("hold_req_ready", bus.req_ready, 1'b0);
            chk("hold_oe", mem_oe, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("rsp_valid_drop", bus.rsp_valid, 1'b0);

        if (err) exp_er++;
        else if (we) exp_st++;
        else exp_ld++;
        if (!err && we)
            for (int i = 0; i < nb; i++) begin
                idx = addr[15:0] + 16'(i);
                ref_mem[idx] = wdata[8*i +: 8];
            end
        $display("txn we=%0b size=%0d uns=%0b addr=%08h wdata=%08h hold=%0d -> lat=%0d err=%0b rdata=%08h",
                 we, size, uns, addr, wdata, hold, lat, bus.rsp_err, bus.rsp_rdata);
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", bus.req_ready, 1'b1);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_mem_oe", mem_oe, 1'b0);
        chk("rst_mem_web", mem_web, 4'hF);
        chk("rst_mem_addr", mem_addr, 14'd0);
        chk("rst_mem_di", mem_di, 32'd0);
`ifdef GS_LSU_PERF_EN
        chk("rst_perf_ld", perf_ld_cnt, 32'd0);
        chk("rst_perf_st", perf_st_cnt, 32'd0);
        chk("rst_perf_err", perf_err_cnt, 32'd0);
`endif
    endtask

    initial begin
        logic [1:0]  rsize;
        logic [31:0] raddr;

        rst = 1'b0;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Fill the 256-byte working window while reset is held.
        @(negedge clk);
        for (int w = 0; w < 64; w++) preload(14'(w), $urandom);
        check_reset_outputs();
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", bus.req_ready, 1'b1);

        // Directed scenarios.
        preload(14'd4, 32'hDEAD_BEEF);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'h0, 0);   // LW
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0013, 32'hA5, 0);  // SB
        preload(14'd4, 32'h8012_3456);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'h0, 0);   // LB signed
        do_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'h0, 0);   // LBU
        do_req(1'b0, 2'd1, 1'b0, 32'h0000_0012, 32'h0, 0);   // LH upper half
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0011, 32'h0, 0);   // misaligned LW
        do_req(1'b0, 2'd3, 1'b0, 32'h0000_0010, 32'h0, 0);   // illegal size
        do_req(1'b1, 2'd1, 1'b0, 32'hFFFF_0022, 32'h1234_BEEF, 0); // SH, high addr bits ignored
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'h0, 5);   // LW with rsp_ready low

        // Reset during ACCESS: no response may appear afterwards.
        bus.req_valid = 1'b1;
        bus.req_we = 1'b0;
        bus.req_size = 2'd2;
        bus.req_addr = 32'h0000_0030;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("abort_oe_before", mem_oe, 1'b1);
        rst = 1'b0;
        #1;
        check_reset_outputs();
        exp_ld = 0;
        exp_st = 0;
        exp_er = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("abort_no_rsp", bus.rsp_valid, 1'b0);
            chk("abort_oe_idle", mem_oe, 1'b0);
        end
        $display("txn reset during ACCESS -> rsp_valid=%0b req_ready=%0b", bus.rsp_valid, bus.req_ready);

`ifdef GS_LSU_PERF_EN
        // Counter scenario: 3 loads, 2 stores, 1 error since reset.
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0, 0);
        do_req(1'b1, 2'd0, 1'b0, 32'h0000_0005, 32'h77, 1);
        do_req(1'b0, 2'd1, 1'b1, 32'h0000_0006, 32'h0, 0);
        do_req(1'b0, 2'd2, 1'b0, 32'h0000_0003, 32'h0, 0);
        do_req(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 0);
        do_req(1'b0, 2'd0, 1'b0, 32'h0000_0009, 32'h0, 2);
        chk("perf_ld_3", perf_ld_cnt, 32'd3);
        chk("perf_st_2", perf_st_cnt, 32'd2);
        chk("perf_err_1", perf_err_cnt, 32'd1);
`endif

        // Randomized traffic within the preloaded window.
        for (int n = 0; n < 80; n++) begin
            rsize = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            raddr = $urandom & 32'hFFFF_00FF;
            if ($urandom_range(0, 3) != 0) begin
                if (rsize == 2'd1) raddr[0] = 1'b0;
                if (rsize == 2'd2) raddr[1:0] = 2'b00;
            end
            do_req($urandom_range(0, 1) == 1, rsize, $urandom_range(0, 1) == 1, raddr, $urandom,
                   int'($urandom_range(0, 3)));
        end

`ifdef GS_LSU_PERF_EN
        chk("perf_ld_total", perf_ld_cnt, 32'(exp_ld));
        chk("perf_st_total", perf_st_cnt, 32'(exp_st));
        chk("perf_err_total", perf_err_cnt, 32'(exp_er));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
